// File: rtl/pdm_sample_scheduler.sv
// rtl/pdm_sample_scheduler.sv - sample-rate scheduler with FIFO and slewed soft-mute for a PDM DAC
module pdm_sample_scheduler #(
    parameter int DATA_BITS  = 12,
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_BITS-1:0]    s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           mute,
    output logic signed [DATA_BITS-1:0]    dac_din,
    output logic                           sample_tick,
    output logic                           underrun,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           muted
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0]            LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic signed [DATA_BITS:0]   STEP     = (DATA_BITS + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {PLAY, RAMP_DOWN, MUTED, RAMP_UP} state_t;

    logic [CNT_W-1:0]               cnt_q;
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]               level_q, level_d;
    state_t                         state_q, state_d;
    logic signed [DATA_BITS-1:0]    dac_q, dac_d;
    logic signed [DATA_BITS-1:0]    target_q, target_d;
    logic signed [DATA_BITS-1:0]    tgt;
    logic                           tick_q, under_q, under_d, muted_q;
    logic signed [DATA_BITS-1:0]    mem_q [FIFO_DEPTH];

    logic                           tick, empty, push, pop;
    logic signed [DATA_BITS-1:0]    head;

    assign tick  = (cnt_q == CNT_LAST);
    assign empty = (level_q == '0);
    assign push  = s_valid && s_ready;
    assign pop   = tick && !empty;
    assign head  = mem_q[rd_ptr_q];

    assign s_ready     = (level_q < LVL_FULL);
    assign fifo_level  = level_q;
    assign dac_din     = dac_q;
    assign sample_tick = tick_q;
    assign underrun    = under_q;
    assign muted       = muted_q;

    // Differences are taken one bit wider so full-scale swings never wrap.
    function automatic logic signed [DATA_BITS-1:0] ramp(input logic signed [DATA_BITS-1:0] cur,
                                                         input logic signed [DATA_BITS-1:0] goal);
        logic signed [DATA_BITS:0] c_ext, g_ext, diff, nxt;
        c_ext = {cur[DATA_BITS-1], cur};
        g_ext = {goal[DATA_BITS-1], goal};
        diff  = g_ext - c_ext;
        if (diff > STEP)
            nxt = c_ext + STEP;
        else if (diff < -STEP)
            nxt = c_ext - STEP;
        else
            nxt = g_ext;
        return nxt[DATA_BITS-1:0];
    endfunction

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        target_d = target_q;
        tgt      = target_q;
        under_d  = 1'b0;
        if (tick) begin
            if (mute) begin
                // Mute from any state: discard the pop and slew toward silence.
                dac_d    = ramp(dac_q, '0);
                target_d = '0;
                state_d  = (dac_d == '0) ? MUTED : RAMP_DOWN;
            end else if (state_q == PLAY) begin
                if (!empty)
                    dac_d = head;
                else
                    under_d = 1'b1;
            end else begin
                if (!empty)
                    tgt = head;
                else if (state_q == RAMP_UP)
                    under_d = 1'b1;
                dac_d    = ramp(dac_q, tgt);
                target_d = tgt;
                state_d  = (dac_d == tgt) ? PLAY : RAMP_UP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= PLAY;
            dac_q    <= '0;
            target_q <= '0;
            tick_q   <= 1'b0;
            under_q  <= 1'b0;
            muted_q  <= 1'b0;
        end else begin
            cnt_q    <= tick ? '0 : cnt_q + CNT_W'(1);
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q  <= level_d;
            state_q  <= state_d;
            dac_q    <= dac_d;
            target_q <= target_d;
            tick_q   <= tick;
            under_q  <= under_d;
            muted_q  <= (state_d == MUTED);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= s_data;
    end

endmodule
